// File: rtl/lc3b_stage_pipe.sv
// lc3b_stage_pipe
// Parametrised LC-3b pipeline backbone between decode and writeback. A chain
// of STAGES registers carries control word, PC, IR and destination info.
// Stage 0 is youngest and stage STAGES-1 is oldest.
// Supported operations:
//   - per-stage stall, which propagates toward stage 0
//   - per-stage flush (squash)
//   - bubble insertion
//   - register-hazard query against every in-flight stage
//   - retire and bubble counters
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_*        instruction from decode; in_ready high when stage 0 captures
//   stall, flush         per-stage hold request / squash
//   q_sr1, q_sr2         source registers to check; sr1_hit/sr2_hit per-stage match
//   stage_valid          registered valid bits of all stages
//   out_*                oldest-stage contents; out_valid already excludes flush
//   retire_cnt           instructions leaving the oldest stage (wraps)
//   bubble_cnt           empty slots leaving the oldest stage (wraps)
module lc3b_stage_pipe #(
  parameter int STAGES     = 4,
  parameter int CW_WIDTH   = 24,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [CW_WIDTH-1:0]   in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_ir,
  input  logic [2:0]            in_dest,
  input  logic                  in_ldreg,
  output logic                  in_ready,
  input  logic [STAGES-1:0]     stall,
  input  logic [STAGES-1:0]     flush,
  input  logic [2:0]            q_sr1,
  input  logic [2:0]            q_sr2,
  output logic [STAGES-1:0]     sr1_hit,
  output logic [STAGES-1:0]     sr2_hit,
  output logic [STAGES-1:0]     stage_valid,
  output logic                  out_valid,
  output logic [CW_WIDTH-1:0]   out_ctrl,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_ir,
  output logic [2:0]            out_dest,
  output logic                  out_ldreg,
  output logic [15:0]           retire_cnt,
  output logic [15:0]           bubble_cnt
);

  logic [STAGES-1:0]     r_v;
  logic [STAGES-1:0]     r_ldreg;
  logic [CW_WIDTH-1:0]   r_ctrl [STAGES];
  logic [DATA_WIDTH-1:0] r_pc   [STAGES];
  logic [DATA_WIDTH-1:0] r_ir   [STAGES];
  logic [2:0]            r_dest [STAGES];
  logic [15:0]           r_retire_cnt;
  logic [15:0]           r_bubble_cnt;

  logic [STAGES-1:0]     w_hold;
  logic [STAGES-1:0]     w_ev;

  // A stage is held when it or any older stage stalls. Computed as an
  // OR-reduce of the stall bits at or above i, so no bit depends on another.
  always_comb begin
    w_hold = '0;
    for (int i = 0; i < STAGES; i++) begin
      w_hold[i] = |(stall >> i);
    end
  end

  assign w_ev     = r_v & ~flush;
  assign in_ready = ~w_hold[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v     <= '0;
      r_ldreg <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_ctrl[i] <= '0;
        r_pc[i]   <= '0;
        r_ir[i]   <= '0;
        r_dest[i] <= '0;
      end
    end else begin
      if (!w_hold[0]) begin
        r_v[0]     <= in_valid;
        r_ctrl[0]  <= in_ctrl;
        r_pc[0]    <= in_pc;
        r_ir[0]    <= in_ir;
        r_dest[0]  <= in_dest;
        r_ldreg[0] <= in_ldreg;
      end else begin
        r_v[0] <= w_ev[0];
      end
      for (int i = 1; i < STAGES; i++) begin
        if (!w_hold[i]) begin
          // Payload moves regardless of validity; a held upstream stage
          // leaves a bubble here.
          r_v[i]     <= w_ev[i-1] & ~w_hold[i-1];
          r_ctrl[i]  <= r_ctrl[i-1];
          r_pc[i]    <= r_pc[i-1];
          r_ir[i]    <= r_ir[i-1];
          r_dest[i]  <= r_dest[i-1];
          r_ldreg[i] <= r_ldreg[i-1];
        end else begin
          r_v[i] <= w_ev[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_cnt <= '0;
      r_bubble_cnt <= '0;
    end else if (!stall[STAGES-1]) begin
      if (w_ev[STAGES-1]) r_retire_cnt <= r_retire_cnt + 16'd1;
      else                r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  // Hazard match uses registered valid only, so there is no path from
  // flush/stall into the hit outputs.
  always_comb begin
    sr1_hit = '0;
    sr2_hit = '0;
    for (int i = 0; i < STAGES; i++) begin
      sr1_hit[i] = r_v[i] & r_ldreg[i] & (r_dest[i] == q_sr1);
      sr2_hit[i] = r_v[i] & r_ldreg[i] & (r_dest[i] == q_sr2);
    end
  end

  assign stage_valid = r_v;
  assign out_valid   = w_ev[STAGES-1];
  assign out_ctrl    = r_ctrl[STAGES-1];
  assign out_pc      = r_pc[STAGES-1];
  assign out_ir      = r_ir[STAGES-1];
  assign out_dest    = r_dest[STAGES-1];
  assign out_ldreg   = r_ldreg[STAGES-1];
  assign retire_cnt  = r_retire_cnt;
  assign bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_lc3b_stage_pipe.sv
module tb_lc3b_stage_pipe;
  localparam int STAGES = 4;
  localparam int CW     = 24;
  localparam int DW     = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [CW-1:0]     in_ctrl = '0;
  logic [DW-1:0]     in_pc = '0;
  logic [DW-1:0]     in_ir = '0;
  logic [2:0]        in_dest = '0;
  logic              in_ldreg = 1'b0;
  logic              in_ready;
  logic [STAGES-1:0] stall = '0;
  logic [STAGES-1:0] flush = '0;
  logic [2:0]        q_sr1 = '0;
  logic [2:0]        q_sr2 = '0;
  logic [STAGES-1:0] sr1_hit, sr2_hit, stage_valid;
  logic              out_valid;
  logic [CW-1:0]     out_ctrl;
  logic [DW-1:0]     out_pc, out_ir;
  logic [2:0]        out_dest;
  logic              out_ldreg;
  logic [15:0]       retire_cnt, bubble_cnt;

  lc3b_stage_pipe #(.STAGES(STAGES), .CW_WIDTH(CW), .DATA_WIDTH(DW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ctrl(in_ctrl), .in_pc(in_pc), .in_ir(in_ir),
    .in_dest(in_dest), .in_ldreg(in_ldreg), .in_ready(in_ready),
    .stall(stall), .flush(flush), .q_sr1(q_sr1), .q_sr2(q_sr2),
    .sr1_hit(sr1_hit), .sr2_hit(sr2_hit), .stage_valid(stage_valid),
    .out_valid(out_valid), .out_ctrl(out_ctrl), .out_pc(out_pc), .out_ir(out_ir),
    .out_dest(out_dest), .out_ldreg(out_ldreg),
    .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] pc;
    logic [DW-1:0] ir;
    logic [CW-1:0] ctrl;
    logic [2:0]    dest;
    logic          ldreg;
    int            acc;
  } item_t;

  item_t sb[$];
  item_t m_e;
  int    n_tests = 0;
  int    n_fail  = 0;
  int    edge_no = 0;
  int    unst    = 0;
  int    pushed  = 0;
  int    killed  = 0;
  bit    lat_chk = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) edge_no++;

  // Scoreboard: push on acceptance, pop and compare on retirement.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!stall[STAGES-1]) unst++;
      if (out_valid && !stall[STAGES-1]) begin
        chk("sb_occupied", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          m_e = sb.pop_front();
          chk("out_pc", out_pc, m_e.pc);
          chk("out_ir", out_ir, m_e.ir);
          chk("out_ctrl", out_ctrl, m_e.ctrl);
          chk("out_dest", out_dest, m_e.dest);
          chk("out_ldreg", out_ldreg, m_e.ldreg);
          if (lat_chk) chk("latency", edge_no - m_e.acc, STAGES - 1);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back('{pc: in_pc, ir: in_ir, ctrl: in_ctrl, dest: in_dest,
                       ldreg: in_ldreg, acc: edge_no + 1});
        pushed++;
      end
    end
  end

  task automatic drive(input logic v, input logic [15:0] pc, input logic [2:0] dst,
                       input logic ld, input logic [3:0] st, input logic [3:0] fl);
    in_valid = v;
    in_pc    = pc;
    in_ir    = ~pc;
    in_ctrl  = {8'hA5, pc};
    in_dest  = dst;
    in_ldreg = ld;
    stall    = st;
    flush    = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic [15:0] pc, input logic [2:0] dst,
                      input logic ld, input logic [3:0] st, input logic [3:0] fl);
    drive(v, pc, dst, ld, st, fl);
    tick();
  endtask

  task automatic go(input logic [15:0] pc);
    send(1'b1, pc, pc[3:1], pc[4], 4'b0000, 4'b0000);
  endtask

  // Instruction the bench squashes: it must never reach the output.
  task automatic kill(input logic [15:0] pc);
    int idx;
    idx = -1;
    foreach (sb[j]) if (idx < 0 && sb[j].pc == pc) idx = j;
    chk("kill_in_sb", 32'(idx >= 0), 1);
    if (idx >= 0) begin
      sb.delete(idx);
      killed++;
    end
  endtask

  // Empty the pipe, then retires = accepted - squashed and every other
  // unstalled edge at the oldest stage was a bubble.
  task automatic drain_and_count(input string tag);
    int ret;
    repeat (STAGES + 2) send(1'b0, 16'h0, 3'd0, 1'b0, 4'b0000, 4'b0000);
    ret = pushed - killed;
    chk({tag, "_sb_drained"}, sb.size(), 0);
    chk({tag, "_retire_cnt"}, retire_cnt, 32'(ret[15:0]));
    chk({tag, "_bubble_cnt"}, bubble_cnt, 32'(16'(unst - ret)));
  endtask

  task automatic clear_model();
    sb.delete();
    pushed = 0;
    killed = 0;
    unst   = 0;
  endtask

  task automatic do_reset();
    drive(1'b0, 16'h0, 3'd0, 1'b0, 4'b0000, 4'b0000);
    rst_n = 1'b0;
    #3;
    chk("rst_stage_valid", stage_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_retire", retire_cnt, 0);
    chk("rst_bubble", bubble_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    stall = 4'b1000;
    #1 chk("rst_in_ready_stalled", in_ready, 0);
    stall = 4'b0000;
    clear_model();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Back-to-back stream with latency check.
    lat_chk = 1'b1;
    for (int k = 0; k < 8; k++) go(16'(2 * k));
    drain_and_count("stream");
    lat_chk = 1'b0;

    // stall[2] for two cycles mid-stream.
    go(16'h0030); go(16'h0032); go(16'h0034);
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 16'h0036, 3'd3, 1'b1, 4'b0100, 4'b0000);
      #1 chk("in_ready_stall", in_ready, 0);
      tick();
      chk("stall_s3_bubble", stage_valid[3], 0);
      chk("stall_s2_held", stage_valid[2], 1);
    end
    go(16'h0036); go(16'h0038);
    drain_and_count("stall");

    // Flush stage 1 while 0x0010 sits there.
    go(16'h0010); go(16'h0012);
    drive(1'b1, 16'h0014, 3'd2, 1'b1, 4'b0000, 4'b0010);
    kill(16'h0010);
    tick();
    go(16'h0016);
    drain_and_count("flush");

    // Flush and stall together on stage 1: valid clears, stage 0 holds.
    go(16'h0020); go(16'h0022);
    drive(1'b1, 16'h0024, 3'd2, 1'b1, 4'b0010, 4'b0010);
    #1 chk("in_ready_fl_st", in_ready, 0);
    kill(16'h0020);
    tick();
    chk("flst_s1_cleared", stage_valid[1], 0);
    chk("flst_s0_kept", stage_valid[0], 1);
    chk("flst_s2_bubble", stage_valid[2], 0);
    go(16'h0024); go(16'h0026);
    drain_and_count("flush_stall");

    // Flush on the oldest stage masks out_valid combinationally.
    go(16'h0040); go(16'h0042); go(16'h0044); go(16'h0046);
    drive(1'b0, 16'h0, 3'd0, 1'b0, 4'b0000, 4'b1000);
    #1 chk("out_valid_flush3", out_valid, 0);
    kill(16'h0040);
    tick();
    drain_and_count("flush_out");

    // Hazard query.
    send(1'b0, 16'h0050, 3'd3, 1'b1, 4'b0000, 4'b0000);
    send(1'b1, 16'h0052, 3'd3, 1'b1, 4'b0000, 4'b0000);
    send(1'b0, 16'h0054, 3'd3, 1'b1, 4'b0000, 4'b0000);
    send(1'b0, 16'h0056, 3'd3, 1'b1, 4'b0000, 4'b0000);
    q_sr1 = 3'd3; q_sr2 = 3'd5;
    #1;
    chk("sr1_hit_r3", sr1_hit, 4'b0100);
    chk("sr2_hit_r5", sr2_hit, 4'b0000);
    q_sr1 = 3'd2;
    #1 chk("sr1_hit_r2", sr1_hit, 4'b0000);
    send(1'b1, 16'h0058, 3'd3, 1'b0, 4'b0000, 4'b0000);
    send(1'b0, 16'h005A, 3'd3, 1'b1, 4'b0000, 4'b0000);
    send(1'b0, 16'h005C, 3'd3, 1'b1, 4'b0000, 4'b0000);
    q_sr1 = 3'd3; q_sr2 = 3'd3;
    #1;
    chk("sr2_hit_noldreg", sr2_hit, 4'b0000);
    chk("sr1_hit_invalid", sr1_hit, 4'b0000);
    drain_and_count("hazard");

    // Asynchronous reset with a full pipe, between edges.
    go(16'h0060); go(16'h0062); go(16'h0064); go(16'h0066);
    drive(1'b0, 16'h0, 3'd0, 1'b0, 4'b0000, 4'b0000);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_stage_valid", stage_valid, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_retire", retire_cnt, 0);
    chk("arst_bubble", bubble_cnt, 0);
    clear_model();
    tick();
    rst_n = 1'b1;
    go(16'h0070);
    drain_and_count("post_arst");

    // Counter wrap after 65536 retires.
    do_reset();
    for (int k = 0; k < 65536; k++) go(16'(k));
    drain_and_count("wrap");
    chk("retire_wrap_zero", retire_cnt, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
